johnson_phase_decoder: RTL and testbench

- Sits directly downstream of the 4-bit Johnson counter.
- Samples the counter's `count` bus each enabled cycle and decodes it to a registered one-hot 8-phase output plus a 3-bit phase index.
- Checks every code and every step against the legal Johnson sequence, and declares lock after a run of consecutive legal steps.
- Flags illegal codes and skipped or held steps with an error pulse and a saturating error counter for system monitoring.

---
 rtl/johnson_pkg.sv | 44 ++++
 rtl/johnson_phase_decoder_if.sv | 42 ++++
 rtl/johnson_code_check.sv | 30 +++
 rtl/johnson_phase_decoder.sv | 157 +++++++++++++++
 tb/tb_johnson_phase_decoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for the Johnson-counter phase decoder:
//   - JOHNSON_BITS / JOHNSON_PHASES : width of the Johnson code and number of
//     phases it walks through.
//   - state_t                       : lock-tracking FSM states.
//   - JOHNSON_CODES                 : legal code table, entry i is the code
//     for phase index i.
//   - next_idx / idx_to_onehot      : small helpers used by the decoder.
// -----------------------------------------------------------------------------
package johnson_pkg;

  localparam int JOHNSON_BITS   = 4;
  localparam int JOHNSON_PHASES = 8;
  localparam int IDX_W          = $clog2(JOHNSON_PHASES);

  typedef logic [JOHNSON_BITS-1:0] code_t;
  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [JOHNSON_PHASES-1:0] phase_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Concatenation lists the highest index first, so JOHNSON_CODES[0] is 0000
  // and JOHNSON_CODES[7] is 0001.
  localparam code_t [JOHNSON_PHASES-1:0] JOHNSON_CODES = {
    4'b0001, 4'b0011, 4'b0111, 4'b1111,
    4'b1110, 4'b1100, 4'b1000, 4'b0000
  };

  // The index is exactly log2(phases) wide, so the 7 -> 0 wrap falls out of
  // plain modulo arithmetic.
  function automatic idx_t next_idx(input idx_t i);
    return i + idx_t'(1);
  endfunction

  function automatic phase_t idx_to_onehot(input idx_t i);
    return phase_t'(1) << i;
  endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// -----------------------------------------------------------------------------
// johnson_phase_decoder_if
// Bundles the sample inputs and the decoded/monitoring outputs of the phase
// decoder.
//   master : drives en, count, clr_err; observes the decoder outputs.
//   slave  : the decoder itself.
// Signals:
//   en        - sample enable
//   count     - Johnson code from the upstream counter
//   clr_err   - synchronous clear of err_count
//   phase     - registered one-hot phase (zero after an illegal code)
//   phase_idx - index of the last legal sample
//   locked    - decoder is locked onto a legal sequence
//   err       - one-cycle fault pulse
//   err_count - saturating fault count (ERR_W bits)
// -----------------------------------------------------------------------------
interface johnson_phase_decoder_if
  import johnson_pkg::*;
#(
  parameter int ERR_W = 8
) ();

  logic             en;
  code_t            count;
  logic             clr_err;
  phase_t           phase;
  idx_t             phase_idx;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output en, count, clr_err,
    input  phase, phase_idx, locked, err, err_count
  );

  modport slave (
    input  en, count, clr_err,
    output phase, phase_idx, locked, err, err_count
  );

endinterface

// File: rtl/johnson_code_check.sv
// -----------------------------------------------------------------------------
// johnson_code_check
// Purely combinational lookup of a Johnson code against the legal table.
// Ports:
//   count - 4-bit code under test
//   legal - high when count is one of the eight legal codes
//   idx   - phase index of count (0 when illegal)
// -----------------------------------------------------------------------------
module johnson_code_check
  import johnson_pkg::*;
(
  input  code_t count,
  output logic  legal,
  output idx_t  idx
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise the tool infers a latch.
  always_comb begin
    legal = 1'b0;
    idx   = '0;
    for (int i = 0; i < JOHNSON_PHASES; i++) begin
      if (count == JOHNSON_CODES[i]) begin
        legal = 1'b1;
        idx   = idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// -----------------------------------------------------------------------------
// johnson_phase_decoder
// Samples a Johnson counter's code on enabled cycles, decodes it into a
// registered one-hot phase plus index, and tracks whether the incoming codes
// follow the legal sequence. Lock is declared after LOCK_CNT consecutive legal
// steps; illegal codes and skipped/held steps raise an err pulse and bump a
// saturating error counter.
// Parameters:
//   LOCK_CNT - consecutive legal steps needed for lock (>= 1)
//   ERR_W    - width of err_count
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - johnson_phase_decoder_if slave (en/count/clr_err in, decoded out)
// -----------------------------------------------------------------------------
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  johnson_phase_decoder_if.slave  bus
);

  localparam int               CTR_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CTR_W-1:0] LOCK_TGT = CTR_W'(LOCK_CNT);

  // Decode of the current input code.
  logic legal;
  idx_t idx;

  johnson_code_check u_code_check (
    .count (bus.count),
    .legal (legal),
    .idx   (idx)
  );

  // FSM and lock tracking.
  state_t           state_q, state_d;
  logic [CTR_W-1:0] lock_ctr_q, lock_ctr_d;
  logic [CTR_W-1:0] lock_ctr_inc;
  idx_t             prev_idx_q;
  logic             step_ok;
  logic             fault;

  // Output-side registers and their next values.
  phase_t           phase_q, phase_d;
  logic             err_q;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             locked;

  assign step_ok      = (idx == next_idx(prev_idx_q));
  assign lock_ctr_inc = lock_ctr_q + CTR_W'(1);

  // State register. prev_idx doubles as the visible phase_idx, since both
  // mean "index of the last legal sample".
  // NOTE: sequential state is written with non-blocking assignments so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      lock_ctr_q <= '0;
      prev_idx_q <= '0;
    end else if (bus.en) begin
      state_q    <= state_d;
      lock_ctr_q <= lock_ctr_d;
      if (legal) begin
        prev_idx_q <= idx;
      end
    end
  end

  // Next-state logic. A wrong step on a legal code resynchronises onto the
  // new index (stays/returns to ACQUIRE) instead of dropping to UNLOCKED.
  always_comb begin
    state_d    = state_q;
    lock_ctr_d = lock_ctr_q;
    fault      = 1'b0;
    if (bus.en) begin
      if (!legal) begin
        state_d    = UNLOCKED;
        lock_ctr_d = '0;
        fault      = 1'b1;
      end else begin
        unique case (state_q)
          UNLOCKED: begin
            state_d    = ACQUIRE;
            lock_ctr_d = '0;
          end
          ACQUIRE: begin
            if (step_ok) begin
              lock_ctr_d = lock_ctr_inc;
              if (lock_ctr_inc == LOCK_TGT) begin
                state_d = LOCKED;
              end
            end else begin
              lock_ctr_d = '0;
              fault      = 1'b1;
            end
          end
          LOCKED: begin
            if (!step_ok) begin
              state_d    = ACQUIRE;
              lock_ctr_d = '0;
              fault      = 1'b1;
            end
          end
          default: begin
            state_d    = UNLOCKED;
            lock_ctr_d = '0;
          end
        endcase
      end
    end
  end

  // Output logic: lock flag straight from state, plus next values for the
  // registered phase and the error counter.
  always_comb begin
    locked      = (state_q == LOCKED);
    phase_d     = legal ? idx_to_onehot(idx) : '0;
    err_count_d = err_count_q;
    if (bus.en) begin
      if (bus.clr_err) begin
        // A fault in the clearing cycle is counted after the clear.
        err_count_d = fault ? ERR_W'(1) : '0;
      end else if (fault && (err_count_q != '1)) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      // fault is already gated by en, so err is a clean single-cycle pulse
      // and drops to zero on disabled cycles.
      err_q       <= fault;
      err_count_q <= err_count_d;
      if (bus.en) begin
        phase_q <= phase_d;
      end
    end
  end

  assign bus.phase     = phase_q;
  assign bus.phase_idx = prev_idx_q;
  assign bus.locked    = locked;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// -----------------------------------------------------------------------------
// tb_johnson_phase_decoder
// Two decoder instances (ERR_W=8 and ERR_W=2, both LOCK_CNT=4) share one
// stimulus stream. A behavioural model tracks "have a reference sample" and
// "length of the current run of legal steps"; lock is run >= LOCK_CNT.
// -----------------------------------------------------------------------------
module tb_johnson_phase_decoder;

  localparam int LC = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  johnson_phase_decoder_if #(.ERR_W(8)) bus ();
  johnson_phase_decoder_if #(.ERR_W(2)) bus2 ();

  johnson_phase_decoder #(.LOCK_CNT(LC), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  johnson_phase_decoder #(.LOCK_CNT(LC), .ERR_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int errors = 0;
  int checks = 0;

  // Legal code sequence, position = phase index.
  logic [3:0] tbl [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                          4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [3:0] bad [5] = '{4'b0100, 4'b0010, 4'b1010, 4'b0101, 4'b1001};

  // Reference model state.
  bit m_have;
  int m_prev, m_run, m_phase, m_idx, m_err, m_cnt8, m_cnt2;

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i] == c) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] next_code();
    return m_have ? tbl[(m_prev + 1) % 8] : tbl[0];
  endfunction

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_run = 0; m_phase = 0;
    m_idx = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] c, input logic clr);
    int k;
    int f;
    if (!e) begin
      m_err = 0;
      return;
    end
    f = 0;
    k = lookup(c);
    if (k < 0) begin
      f = 1; m_have = 0; m_run = 0; m_phase = 0;
    end else begin
      if (!m_have) begin
        m_have = 1; m_run = 0;
      end else if (k == (m_prev + 1) % 8) begin
        m_run = (m_run + 1 > LC) ? LC : m_run + 1;
      end else begin
        m_run = 0; f = 1;
      end
      m_prev = k; m_idx = k; m_phase = 1 << k;
    end
    m_err = f;
    if (clr) begin
      m_cnt8 = f; m_cnt2 = f;
    end else if (f != 0) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".phase"},     32'(bus.phase),      32'(m_phase));
    check({tag, ".phase_idx"}, 32'(bus.phase_idx),  32'(m_idx));
    check({tag, ".locked"},    32'(bus.locked),     32'(m_have && m_run >= LC));
    check({tag, ".err"},       32'(bus.err),        32'(m_err));
    check({tag, ".err_count"}, 32'(bus.err_count),  32'(m_cnt8));
    check({tag, ".err_cnt2"},  32'(bus2.err_count), 32'(m_cnt2));
    check({tag, ".phase2"},    32'(bus2.phase),     32'(m_phase));
  endtask

  task automatic step(input logic e, input logic [3:0] c, input logic clr, input string tag);
    bus.en  = e; bus.count  = c; bus.clr_err  = clr;
    bus2.en = e; bus2.count = c; bus2.clr_err = clr;
    @(posedge clk);
    #1;
    model_step(e, c, clr);
    check_all(tag);
  endtask

  initial begin
    logic       e;
    logic       clr;
    logic [3:0] c;
    int         r;

    rst = 1'b1;
    bus.en = 0;  bus.count = 0;  bus.clr_err = 0;
    bus2.en = 0; bus2.count = 0; bus2.clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Free-running from 0000: phase follows one cycle later, lock after 5th.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, tbl[i], 1'b0, "free");
      check("free.phase_const", 32'(bus.phase), 32'(1) << i);
      check("free.locked_const", 32'(bus.locked), (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 5; i < 12; i++) step(1'b1, tbl[i % 8], 1'b0, "run");

    // Illegal code while locked at index 3.
    step(1'b1, 4'b1010, 1'b0, "illegal");
    check("illegal.err", 32'(bus.err), 32'd1);
    check("illegal.phase", 32'(bus.phase), 32'd0);
    check("illegal.locked", 32'(bus.locked), 32'd0);
    check("illegal.err_count", 32'(bus.err_count), 32'd1);
    check("illegal.idx_hold", 32'(bus.phase_idx), 32'd3);

    // Resume: acquire on 1111, relock after 4 further legal steps.
    for (int i = 4; i < 9; i++) begin
      step(1'b1, tbl[i % 8], 1'b0, "relock");
      check("relock.locked", 32'(bus.locked), (i == 8) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i < 4; i++) step(1'b1, tbl[i], 1'b0, "to3");

    // Skip from index 3 to index 6.
    step(1'b1, tbl[6], 1'b0, "skip");
    check("skip.err", 32'(bus.err), 32'd1);
    check("skip.phase", 32'(bus.phase), 32'h40);
    check("skip.locked", 32'(bus.locked), 32'd0);
    for (int i = 7; i < 11; i++) step(1'b1, tbl[i % 8], 1'b0, "skip_relock");
    check("skip_relock.locked", 32'(bus.locked), 32'd1);

    // Hold fault.
    step(1'b1, tbl[3], 1'b0, "hold_a");
    step(1'b1, tbl[3], 1'b0, "hold_b");
    check("hold.err", 32'(bus.err), 32'd1);
    check("hold.locked", 32'(bus.locked), 32'd0);
    check("hold.phase", 32'(bus.phase), 32'h08);

    // Wrap 7 -> 0 is a legal step.
    step(1'b1, tbl[4], 1'b0, "pre_wrap");
    step(1'b1, tbl[5], 1'b0, "pre_wrap");
    for (int i = 6; i < 10; i++) begin
      step(1'b1, tbl[i % 8], 1'b0, "wrap");
      check("wrap.err", 32'(bus.err), 32'd0);
      check("wrap.phase", 32'(bus.phase), 32'(1) << (i % 8));
    end

    // Saturation of the 2-bit counter, then clear together with a fault.
    for (int i = 0; i < 5; i++) step(1'b1, bad[i], 1'b0, "sat");
    check("sat.err_cnt2", 32'(bus2.err_count), 32'd3);
    step(1'b1, 4'b1011, 1'b1, "clr_fault");
    check("clr_fault.err_cnt2", 32'(bus2.err_count), 32'd1);
    check("clr_fault.err_count", 32'(bus.err_count), 32'd1);

    // Enable low: everything frozen while count keeps changing.
    for (int i = 0; i < 3; i++) step(1'b1, tbl[i], 1'b0, "pre_hold");
    step(1'b0, tbl[3], 1'b0, "en_low");
    step(1'b0, 4'b1010, 1'b0, "en_low");
    step(1'b0, tbl[6], 1'b0, "en_low");
    check("en_low.phase", 32'(bus.phase), 32'h04);
    check("en_low.err", 32'(bus.err), 32'd0);
    step(1'b1, tbl[3], 1'b0, "after_en");
    check("after_en.err", 32'(bus.err), 32'd0);

    // Randomised traffic: mostly legal steps, some corrupt codes and gaps.
    for (int n = 0; n < 400; n++) begin
      e   = ($urandom_range(0, 9) != 0);
      r   = int'($urandom_range(0, 19));
      if (r < 14)      c = next_code();
      else if (r < 17) c = 4'($urandom_range(0, 15));
      else             c = tbl[$urandom_range(0, 7)];
      clr = e && ($urandom_range(0, 29) == 0);
      step(e, c, clr, "rand");
    end

    // Asynchronous reset between edges.
    for (int i = 0; i < 6; i++) step(1'b1, next_code(), 1'b0, "pre_rst");
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst = 1'b0;
    step(1'b1, tbl[5], 1'b0, "post_rst");
    check("post_rst.err", 32'(bus.err), 32'd0);
    check("post_rst.phase", 32'(bus.phase), 32'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
